shifter_adc_filter: RTL and testbench

//  Parametrised post-processor for the shifter position ADC. Consumes the modular ADC response

---
 rtl/shifter_adc_pkg.sv | 26 ++
 rtl/shifter_adc_hyst_cmp.sv | 35 +++
 rtl/shifter_adc_filter.sv | 206 ++++++++++++++++++++
 tb/tb_shifter_adc_filter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_adc_pkg.sv
// Shared constants and types for the shifter position ADC post-processor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shifter_adc_pkg;

   // CSR word addresses
   localparam logic [6:0] ADDR_CTRL        = 7'h00;
   localparam logic [6:0] ADDR_NEW         = 7'h01;
   localparam logic [6:0] ADDR_IRQ_MASK    = 7'h02;
   localparam logic [6:0] ADDR_IRQ_STATUS  = 7'h03;
   localparam logic [6:0] ADDR_ABOVE       = 7'h04;
   localparam logic [6:0] ADDR_RESULT_BASE = 7'h10;
   localparam logic [6:0] ADDR_THR_BASE    = 7'h20;   // THR_HI at +2ch, THR_LO at +2ch+1

   // CTRL register bit positions
   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_CLR_BIT = 1;

   // Default sample geometry; the accumulator is sized for the largest window
   localparam int SAMPLE_W     = 12;
   localparam int AVG_LOG2_MAX = 6;

   typedef logic [SAMPLE_W-1:0]              sample_t;
   typedef logic [SAMPLE_W+AVG_LOG2_MAX-1:0] acc_t;

endpackage

// File: rtl/shifter_adc_hyst_cmp.sv
// One channel's hysteresis comparator: tracks ABOVE and flags each toggle.
// Latency: toggle is combinational on upd; ABOVE updates on the same clock edge as RESULT.
// Backpressure: none; evaluates every completed average.
module shifter_adc_hyst_cmp #(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              upd,
   input  logic [DATA_W-1:0] avg,
   input  logic [DATA_W-1:0] thr_hi,
   input  logic [DATA_W-1:0] thr_lo,
   output logic              above,
   output logic              toggle
);

   // Strict comparisons: a result exactly on a threshold never toggles
   always_comb begin
      toggle = 1'b0;
      if (upd) begin
         toggle = above ? (avg < thr_lo) : (avg > thr_hi);
      end
   end

   // ABOVE state flips on each toggle; CLR returns it to below
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         above <= 1'b0;
      end else if (toggle) begin
         above <= ~above;
      end
   end

endmodule

// File: rtl/shifter_adc_filter.sv
// Box-averages 2**AVG_LOG2 ADC samples per channel, exposes results via CSRs, raises a masked IRQ.
// Latency: average readable 1 cycle after the closing sample; CSR read data 1 cycle after csr_read; irq 1 cycle after status.
// Backpressure: none; one ADC sample per cycle always accepted, CSR access never stalls.
// Build option SHIFTER_ADC_HYST_EN: per-channel hysteresis comparators drive IRQ_STATUS instead of NEW.
module shifter_adc_filter
   import shifter_adc_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int DATA_W   = SAMPLE_W,
   parameter int CH_W     = 5,
   parameter int CH_BASE  = 1,
   parameter int AVG_LOG2 = 3
) (
   input  logic              clock_clk,
   input  logic              reset_sink_reset,
   input  logic              adc_response_valid,
   input  logic [CH_W-1:0]   adc_response_channel,
   input  logic [DATA_W-1:0] adc_response_data,
   input  logic [6:0]        csr_address,
   input  logic              csr_read,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   output logic [31:0]       csr_readdata,
   output logic              irq
);

   localparam int ACC_W = DATA_W + AVG_LOG2;   // sum of a full window cannot overflow
   localparam int CNT_W = AVG_LOG2 + 1;        // extra bit keeps AVG_LOG2=0 legal
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic                           en;
   logic [NUM_CH-1:0]              new_flags;
   logic [NUM_CH-1:0]              irq_mask;
   logic [NUM_CH-1:0]              irq_status;
   logic [NUM_CH-1:0]              done;
   logic [NUM_CH-1:0]              sts_set;
   logic [NUM_CH-1:0]              above;
   logic [NUM_CH-1:0][DATA_W-1:0]  result;
`ifdef SHIFTER_ADC_HYST_EN
   logic [NUM_CH-1:0][DATA_W-1:0]  thr_hi_q;
   logic [NUM_CH-1:0][DATA_W-1:0]  thr_lo_q;
`endif
   int                             idx;
   logic                           accept;
   logic                           wr_ctrl;
   logic                           clr_pulse;
   logic                           wr_mask;
   logic [NUM_CH-1:0]              w1c_new;
   logic [NUM_CH-1:0]              w1c_sts;
   logic [31:0]                    rd_data;
   logic                           wdata_unused;

   assign wdata_unused = ^csr_writedata;

   // CSR write decode; CLR is a pulse and never stored
   always_comb begin
      wr_ctrl   = csr_write && (csr_address == ADDR_CTRL);
      clr_pulse = wr_ctrl && csr_writedata[CTRL_CLR_BIT];
      wr_mask   = csr_write && (csr_address == ADDR_IRQ_MASK);
      w1c_new   = '0;
      w1c_sts   = '0;
      if (csr_write && (csr_address == ADDR_NEW)) begin
         w1c_new = csr_writedata[NUM_CH-1:0];
      end
      if (csr_write && (csr_address == ADDR_IRQ_STATUS)) begin
         w1c_sts = csr_writedata[NUM_CH-1:0];
      end
   end

   // Map physical channel to internal index; drop disabled, out-of-range and CLR-cycle samples
   always_comb begin
      idx    = int'(adc_response_channel) - CH_BASE;
      accept = adc_response_valid && en && !clr_pulse && (idx >= 0) && (idx < NUM_CH);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [ACC_W-1:0]  acc;
      logic [ACC_W-1:0]  sum;
      logic [CNT_W-1:0]  cnt;
      logic [DATA_W-1:0] res;
      logic [DATA_W-1:0] avg;
      logic              hit;

      assign hit       = accept && (idx == g);
      assign sum       = acc + ACC_W'(adc_response_data);
      assign avg       = DATA_W'(sum >> AVG_LOG2);
      assign done[g]   = hit && (cnt == CNT_LAST);
      assign result[g] = res;

      // Accumulate the window; the closing sample is folded into the published average
      always_ff @(posedge clock_clk) begin
         if (reset_sink_reset || clr_pulse) begin
            acc <= '0;
            cnt <= '0;
            res <= '0;
         end else if (hit) begin
            if (done[g]) begin
               acc <= '0;
               cnt <= '0;
               res <= avg;
            end else begin
               acc <= sum;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end

`ifdef SHIFTER_ADC_HYST_EN
      logic [DATA_W-1:0] thr_hi;
      logic [DATA_W-1:0] thr_lo;

      // Threshold registers survive CLR; only reset clears them
      always_ff @(posedge clock_clk) begin
         if (reset_sink_reset) begin
            thr_hi <= '0;
            thr_lo <= '0;
         end else if (csr_write) begin
            if (csr_address == 7'(ADDR_THR_BASE + 2 * g)) thr_hi <= csr_writedata[DATA_W-1:0];
            if (csr_address == 7'(ADDR_THR_BASE + 2 * g + 1)) thr_lo <= csr_writedata[DATA_W-1:0];
         end
      end

      assign thr_hi_q[g] = thr_hi;
      assign thr_lo_q[g] = thr_lo;

      shifter_adc_hyst_cmp #(
         .DATA_W (DATA_W)
      ) u_hyst_cmp (
         .clk    (clock_clk),
         .rst    (reset_sink_reset),
         .clr    (clr_pulse),
         .upd    (done[g]),
         .avg    (avg),
         .thr_hi (thr_hi),
         .thr_lo (thr_lo),
         .above  (above[g]),
         .toggle (sts_set[g])
      );
`endif
   end

`ifndef SHIFTER_ADC_HYST_EN
   // Without comparators every new average is an interrupt source
   assign above   = '0;
   assign sts_set = done;
`endif

   // Control, flag and mask registers; a set in the same cycle as W1C wins
   always_ff @(posedge clock_clk) begin
      if (reset_sink_reset) begin
         en         <= 1'b0;
         new_flags  <= '0;
         irq_status <= '0;
         irq_mask   <= '0;
      end else begin
         if (wr_ctrl) en <= csr_writedata[CTRL_EN_BIT];
         if (wr_mask) irq_mask <= csr_writedata[NUM_CH-1:0];
         if (clr_pulse) begin
            new_flags  <= '0;
            irq_status <= '0;
         end else begin
            new_flags  <= (new_flags & ~w1c_new) | done;
            irq_status <= (irq_status & ~w1c_sts) | sts_set;
         end
      end
   end

   // Registered interrupt level from the visible status and mask
   always_ff @(posedge clock_clk) begin
      if (reset_sink_reset) begin
         irq <= 1'b0;
      end else begin
         irq <= |(irq_status & irq_mask);
      end
   end

   // Read mux; unmapped addresses return zero
   always_comb begin
      rd_data = '0;
      case (csr_address)
         ADDR_CTRL:       rd_data[CTRL_EN_BIT] = en;
         ADDR_NEW:        rd_data[NUM_CH-1:0]  = new_flags;
         ADDR_IRQ_MASK:   rd_data[NUM_CH-1:0]  = irq_mask;
         ADDR_IRQ_STATUS: rd_data[NUM_CH-1:0]  = irq_status;
         ADDR_ABOVE:      rd_data[NUM_CH-1:0]  = above;
         default:         ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
         if (csr_address == 7'(ADDR_RESULT_BASE + i)) rd_data[DATA_W-1:0] = result[i];
`ifdef SHIFTER_ADC_HYST_EN
         if (csr_address == 7'(ADDR_THR_BASE + 2 * i)) rd_data[DATA_W-1:0] = thr_hi_q[i];
         if (csr_address == 7'(ADDR_THR_BASE + 2 * i + 1)) rd_data[DATA_W-1:0] = thr_lo_q[i];
`endif
      end
   end

   // Read data captured on csr_read and held otherwise
   always_ff @(posedge clock_clk) begin
      if (reset_sink_reset) begin
         csr_readdata <= '0;
      end else if (csr_read) begin
         csr_readdata <= rd_data;
      end
   end

endmodule

// File: tb/tb_shifter_adc_filter.sv
// Directed self-checking bench for shifter_adc_filter (default parameters).
// Latency: inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpressure: n/a; honours SHIFTER_ADC_HYST_EN for build-dependent expectations.
module tb_shifter_adc_filter;

`ifdef SHIFTER_ADC_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [4:0]  ch;
   logic [11:0] dat;
   logic [6:0]  addr;
   logic        rd;
   logic        wr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;
   logic [31:0] r;

   always #5 clk = ~clk;

   shifter_adc_filter dut (
      .clock_clk            (clk),
      .reset_sink_reset     (rst),
      .adc_response_valid   (valid),
      .adc_response_channel (ch),
      .adc_response_data    (dat),
      .csr_address          (addr),
      .csr_read             (rd),
      .csr_write            (wr),
      .csr_writedata        (wdata),
      .csr_readdata         (rdata),
      .irq                  (irq)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic csr_wr(input int a, input int d);
      addr  = 7'(a);
      wdata = 32'(d);
      wr    = 1'b1;
      tick();
      wr    = 1'b0;
   endtask

   task automatic csr_rd(input int a, output logic [31:0] d);
      addr = 7'(a);
      rd   = 1'b1;
      tick();
      rd   = 1'b0;
      d    = rdata;
   endtask

   task automatic rd_chk(input string tag, input int a, input int exp);
      logic [31:0] v;
      csr_rd(a, v);
      check(tag, v, 32'(exp));
   endtask

   task automatic samp(input int c, input int v);
      ch    = 5'(c);
      dat   = 12'(v);
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   task automatic samp_n(input int c, input int v, input int n);
      for (int k = 0; k < n; k++) samp(c, v);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; ch = '0; dat = '0;
      addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
      repeat (3) tick();
      check("rst_readdata", rdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      tick();

      // 1: every mapped CSR reads zero after reset
      for (int a = 0; a <= 4; a++) rd_chk("rst_csr", a, 0);
      for (int a = 16; a < 24; a++) rd_chk("rst_result", a, 0);
      for (int a = 32; a < 48; a++) rd_chk("rst_thr", a, 0);

      // 2: basic 8-sample average on ch1 -> internal channel 0
      csr_wr(0, 1);
      rd_chk("t2_ctrl_en", 0, 1);
      for (int i = 0; i < 8; i++) samp(1, 100 + i);
      rd_chk("t2_result0", 16, 'h67);
      rd_chk("t2_new", 1, 1);
      tick();
      check("t2_readdata_hold", rdata, 32'd1);
      rd_chk("t2_status", 3, 1);
      rd_chk("t2_above", 4, HYST ? 1 : 0);
      check("t2_irq_masked", 32'(irq), 32'd0);
      csr_wr(1, 1);
      rd_chk("t2_new_w1c", 1, 0);
      csr_wr(3, 'hFF);
      rd_chk("t2_status_w1c", 3, 0);

      // 3: out-of-range channels ignored and do not touch any window
      samp(0, 500);
      samp(9, 500);
      samp(31, 500);
      rd_chk("t3_new_none", 1, 0);
      samp_n(1, 10, 7);
      rd_chk("t3_cnt_unchanged", 1, 0);
      samp(1, 10);
      rd_chk("t3_result0", 16, 10);
      rd_chk("t3_new0", 1, 1);
      samp_n(8, 4095, 8);
      rd_chk("t3_result7_max", 23, 'hFFF);
      rd_chk("t3_new_07", 1, 'h81);
      rd_chk("unmapped_05", 5, 0);
      rd_chk("unmapped_18", 'h18, 0);
      rd_chk("unmapped_7f", 'h7F, 0);

      // EN dropped mid-window holds the partial window
      csr_wr(1, 'hFF);
      samp_n(1, 200, 4);
      csr_wr(0, 0);
      samp_n(1, 999, 3);
      rd_chk("en_off_ctrl", 0, 0);
      csr_wr(0, 1);
      samp_n(1, 200, 3);
      rd_chk("en_resume_new", 1, 0);
      samp(1, 200);
      rd_chk("en_resume_result", 16, 200);
      rd_chk("en_resume_newset", 1, 1);

      // CLR wipes results and flags, keeps EN
      csr_wr(0, 3);
      rd_chk("clr_new", 1, 0);
      rd_chk("clr_status", 3, 0);
      rd_chk("clr_above", 4, 0);
      rd_chk("clr_result0", 16, 0);
      rd_chk("clr_result7", 23, 0);
      rd_chk("clr_ctrl", 0, 1);

      // 4: thresholds, mask and interrupt timing
      csr_wr('h20, 2000);
      csr_wr('h21, 1000);
      rd_chk("t4_thr_hi", 'h20, HYST ? 2000 : 0);
      rd_chk("t4_thr_lo", 'h21, HYST ? 1000 : 0);
      csr_wr(2, 1);
      rd_chk("t4_mask", 2, 1);
      samp_n(1, 2100, 8);
      check("t4_irq_not_yet", 32'(irq), 32'd0);
      tick();
      check("t4_irq_set", 32'(irq), 32'd1);
      rd_chk("t4_result_2100", 16, 2100);
      rd_chk("t4_above_hi", 4, HYST ? 1 : 0);
      rd_chk("t4_status_hi", 3, 1);
      csr_wr(3, 1);
      rd_chk("t4_status_w1c", 3, 0);
      check("t4_irq_clear", 32'(irq), 32'd0);
      samp_n(1, 1500, 8);
      tick();
      rd_chk("t4_result_1500", 16, 1500);
      rd_chk("t4_status_mid", 3, HYST ? 0 : 1);
      rd_chk("t4_above_mid", 4, HYST ? 1 : 0);
      check("t4_irq_mid", 32'(irq), HYST ? 32'd0 : 32'd1);
      csr_wr(3, 1);
      samp_n(1, 900, 8);
      tick();
      rd_chk("t4_result_900", 16, 900);
      rd_chk("t4_above_lo", 4, 0);
      rd_chk("t4_status_lo", 3, 1);
      check("t4_irq_lo", 32'(irq), 32'd1);

      // 5: W1C in the same cycle as a new set -> set wins
      samp_n(1, 2500, 7);
      ch = 5'd1; dat = 12'd2500; valid = 1'b1;
      addr = 7'h03; wdata = 32'd1; wr = 1'b1;
      tick();
      valid = 1'b0; wr = 1'b0;
      rd_chk("t5_status_kept", 3, 1);
      check("t5_irq_high", 32'(irq), 32'd1);
      tick();
      check("t5_irq_still_high", 32'(irq), 32'd1);
      rd_chk("t5_above", 4, HYST ? 1 : 0);

      // 6: CLR after 5 of 8 samples, with a sample in the CLR cycle that must be dropped
      csr_wr(1, 'hFF);
      csr_wr(3, 'hFF);
      samp_n(1, 1000, 5);
      ch = 5'd1; dat = 12'd4000; valid = 1'b1;
      addr = 7'h00; wdata = 32'd3; wr = 1'b1;
      tick();
      valid = 1'b0; wr = 1'b0;
      rd_chk("t6_new_cleared", 1, 0);
      rd_chk("t6_result_cleared", 16, 0);
      samp_n(1, 50, 7);
      rd_chk("t6_no_early_close", 1, 0);
      samp(1, 50);
      rd_chk("t6_result_50", 16, 50);
      rd_chk("t6_new_set", 1, 1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
